// File: rtl/utopia_pkg.sv
// Shared constants, read-FSM state type and header-check helper for the Utopia PHY cell source.
package utopia_pkg;

   localparam int         CELL_BYTES = 53;
   localparam int         HEC_IDX    = 4;
   localparam logic [7:0] HEC_COSET  = 8'h55;
   localparam int         IDX_W      = 6;

   typedef enum logic {IDLE, SEND} utopia_tx_state_e;

   // CRC-8, polynomial x^8+x^2+x+1, init 0, header bits taken MSB first.
   function automatic logic [7:0] hec_crc8(input logic [31:0] hdr);
      logic [7:0] crc;
      logic       fb;
      crc = '0;
      for (int i = 31; i >= 0; i--) begin
         fb  = crc[7] ^ hdr[i];
         crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return crc;
   endfunction

endpackage

// File: rtl/utopia_cell_buf.sv
// Multi-slot cell store: slots fill and drain in strict FIFO order, one whole cell per slot.
module utopia_cell_buf
   import utopia_pkg::*;
#(
   parameter int CELLS = 2,
   parameter int CW    = $clog2(CELLS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [7:0]       wr_data,
   input  logic             commit,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic             free,
   output logic [7:0]       rd_data,
   output logic             cell_ready,
   output logic [CW-1:0]    committed_cnt
);

   localparam int SW    = (CELLS > 1) ? $clog2(CELLS) : 1;
   localparam int DEPTH = CELLS * CELL_BYTES;
   localparam int AW    = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [SW-1:0] wr_slot;
   logic [SW-1:0] rd_slot;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;

   function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
      return (int'(s) == CELLS - 1) ? '0 : s + 1'b1;
   endfunction

   assign wr_addr       = AW'(int'(wr_slot) * CELL_BYTES + int'(wr_idx));
   assign rd_addr       = AW'(int'(rd_slot) * CELL_BYTES + int'(rd_idx));
   assign rd_data       = mem[rd_addr];
   assign committed_cnt = count;

   // count covers every committed slot, including the one being read out.
   always_comb begin
      count_next = count;
      case ({commit, free})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_slot    <= '0;
         rd_slot    <= '0;
         count      <= '0;
         cell_ready <= 1'b0;
      end else begin
         count      <= count_next;
         cell_ready <= (count_next < CW'(CELLS));
         if (commit) wr_slot <= slot_inc(wr_slot);
         if (free)   rd_slot <= slot_inc(rd_slot);
      end
   end

endmodule

// File: rtl/utopia_phy_tx.sv
// Utopia Level 1 PHY-side cell source: frames an upstream byte stream into cells and plays them out.
// Build option UTOPIA_HEC_GEN_EN regenerates header byte 4 (HEC) at write time.
module utopia_phy_tx
   import utopia_pkg::*;
#(
   parameter int CELLS  = 2,
   parameter int DROP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        cell_data,
   input  logic              cell_valid,
   input  logic              cell_sop,
   output logic              cell_ready,
   output logic [7:0]        Rx_data,
   output logic              Rx_soc,
   input  logic              Rx_en,
   output logic              Rx_clav,
   output logic [DROP_W-1:0] drop_cnt,
   output utopia_tx_state_e  dbg_state
);

   localparam int               CW   = $clog2(CELLS + 1);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(CELL_BYTES - 1);

   // Upstream handshake: a byte transfers on every rising edge where cell_valid and
   // cell_ready are both high; cell_valid never waits on cell_ready.
   logic             accept;
   logic             in_cell;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] wr_pos;
   logic             wr_en;
   logic             commit;
   logic             drop;
   logic [7:0]       wr_byte;

   utopia_tx_state_e state;
   logic [IDX_W-1:0] rd_idx;
   logic [7:0]       rd_data;
   logic             launch;
   logic             free;
   logic             next_send;
   logic [CW-1:0]    busy;
   logic             clav_next;
   logic [CW-1:0]    committed_cnt;

   assign accept = cell_valid && cell_ready;
   assign wr_pos = cell_sop ? '0 : wr_idx;
   assign wr_en  = accept && (cell_sop || in_cell);
   assign commit = accept && !cell_sop && in_cell && (wr_idx == LAST);
   assign drop   = accept && cell_sop && in_cell;

`ifdef UTOPIA_HEC_GEN_EN
   logic [31:0] hdr;

   // Only the last four header bytes survive in the shift register when byte 4 arrives.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hdr <= '0;
      end else if (wr_en && (wr_pos < IDX_W'(HEC_IDX))) begin
         hdr <= {hdr[23:0], cell_data};
      end
   end

   assign wr_byte = (wr_pos == IDX_W'(HEC_IDX)) ? (hec_crc8(hdr) ^ HEC_COSET) : cell_data;
`else
   assign wr_byte = cell_data;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_cell  <= 1'b0;
         wr_idx   <= '0;
         drop_cnt <= '0;
      end else if (accept) begin
         if (cell_sop) begin
            in_cell <= 1'b1;
            wr_idx  <= IDX_W'(1);
            if (drop && (drop_cnt != {DROP_W{1'b1}})) drop_cnt <= drop_cnt + 1'b1;
         end else if (in_cell) begin
            if (wr_idx == LAST) begin
               in_cell <= 1'b0;
               wr_idx  <= '0;
            end else begin
               wr_idx <= wr_idx + 1'b1;
            end
         end
      end
   end

   utopia_cell_buf #(.CELLS(CELLS), .CW(CW)) u_buf (
      .clk           (clk),
      .rst           (rst),
      .wr_en         (wr_en),
      .wr_idx        (wr_pos),
      .wr_data       (wr_byte),
      .commit        (commit),
      .rd_idx        (rd_idx),
      .free          (free),
      .rd_data       (rd_data),
      .cell_ready    (cell_ready),
      .committed_cnt (committed_cnt)
   );

   assign launch    = (state == IDLE) && !Rx_en && Rx_clav;
   assign free      = (state == SEND) && !Rx_en && (rd_idx == LAST);
   assign next_send = (state == IDLE) ? launch : !free;

   // Clav counts committed cells not yet started; a commit on this edge shows up one edge later.
   assign busy      = CW'(free) + CW'(next_send);
   assign clav_next = (committed_cnt != busy);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         rd_idx  <= '0;
         Rx_data <= '0;
         Rx_soc  <= 1'b0;
         Rx_clav <= 1'b0;
      end else begin
         Rx_clav <= clav_next;
         Rx_soc  <= 1'b0;
         case (state)
            IDLE: begin
               if (launch) begin
                  Rx_data <= rd_data;
                  Rx_soc  <= 1'b1;
                  rd_idx  <= IDX_W'(1);
                  state   <= SEND;
               end
            end
            SEND: begin
               if (!Rx_en) begin
                  Rx_data <= rd_data;
                  if (rd_idx == LAST) begin
                     rd_idx <= '0;
                     state  <= IDLE;
                  end else begin
                     rd_idx <= rd_idx + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_utopia_phy_tx.sv
// Directed scoreboard bench for utopia_phy_tx (CELLS=2); honours UTOPIA_HEC_GEN_EN when defined.
module tb_utopia_phy_tx;
   import utopia_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [7:0]       cell_data;
   logic             cell_valid;
   logic             cell_sop;
   logic             cell_ready;
   logic [7:0]       Rx_data;
   logic             Rx_soc;
   logic             Rx_en;
   logic             Rx_clav;
   logic [7:0]       drop_cnt;
   utopia_tx_state_e dbg_state;

   int         n_vec = 0;
   int         n_fail = 0;
   int         rx_count = 0;
   logic       launch_pend = 1'b0;
   logic [8:0] exp_q[$];
   logic [7:0] tx_cell [53];
   logic [7:0] exp_cell [53];

   always #5 clk = ~clk;

   utopia_phy_tx #(.CELLS(2), .DROP_W(8)) dut (
      .clk        (clk),
      .rst        (rst_n),
      .cell_data  (cell_data),
      .cell_valid (cell_valid),
      .cell_sop   (cell_sop),
      .cell_ready (cell_ready),
      .Rx_data    (Rx_data),
      .Rx_soc     (Rx_soc),
      .Rx_en      (Rx_en),
      .Rx_clav    (Rx_clav),
      .drop_cnt   (drop_cnt),
      .dbg_state  (dbg_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   function automatic logic [7:0] tb_hec(input logic [31:0] hdr);
      logic [7:0] c;
      c = 8'h00;
      for (int k = 0; k < 4; k++) begin
         c = c ^ hdr[31-8*k -: 8];
         for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

   // Monitor: a byte is due in the cycle after an edge that saw Rx_en low with a cell started or available.
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (launch_pend) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_byte: got soc=%0b data=%0h, required no byte", Rx_soc, Rx_data);
            end else begin
               e = exp_q.pop_front();
               check("rx_byte", {23'd0, Rx_soc, Rx_data}, {23'd0, e});
               rx_count++;
            end
         end
         #3;
         launch_pend = rst_n && !Rx_en && ((dbg_state == SEND) || Rx_clav);
      end
   end

   task automatic put_byte(input logic [7:0] d, input logic sop);
      int t;
      cell_data  = d;
      cell_sop   = sop;
      cell_valid = 1'b1;
      t = 0;
      while (!cell_ready && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (!cell_ready) begin
         n_vec++;
         n_fail++;
         $display("FAIL put_byte_timeout: cell_ready=0, required 1");
      end
      @(negedge clk);
      cell_valid = 1'b0;
      cell_sop   = 1'b0;
   endtask

   task automatic fill_cell(input logic [7:0] base, input logic [7:0] incr);
      for (int i = 0; i < 53; i++) begin
         tx_cell[i]  = base + 8'(i) * incr;
         exp_cell[i] = tx_cell[i];
      end
`ifdef UTOPIA_HEC_GEN_EN
      exp_cell[4] = tb_hec({tx_cell[0], tx_cell[1], tx_cell[2], tx_cell[3]}) ^ 8'h55;
`endif
   endtask

   task automatic send_cell();
      for (int i = 0; i < 53; i++) exp_q.push_back({(i == 0), exp_cell[i]});
      for (int i = 0; i < 53; i++) put_byte(tx_cell[i], (i == 0));
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || dbg_state != IDLE) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0 || dbg_state != IDLE) begin
         n_vec++;
         n_fail++;
         $display("FAIL drain_timeout: %0d bytes outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic wait_rx(input int target);
      int t;
      t = 0;
      while (rx_count < target && t < 1000) begin
         @(negedge clk);
         #2;
         t++;
      end
      if (rx_count < target) begin
         n_vec++;
         n_fail++;
         $display("FAIL wait_rx_timeout: got %0d bytes, required %0d", rx_count, target);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exhausted, required completion");
      n_fail++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      int base;
      cell_data  = 8'h00;
      cell_valid = 1'b0;
      cell_sop   = 1'b0;
      Rx_en      = 1'b1;
      rst_n      = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_data", {24'd0, Rx_data}, 32'h0);
      check("rst_soc", {31'd0, Rx_soc}, 32'h0);
      check("rst_clav", {31'd0, Rx_clav}, 32'h0);
      check("rst_ready", {31'd0, cell_ready}, 32'h0);
      check("rst_drop", {24'd0, drop_cnt}, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("ready_after_rst", {31'd0, cell_ready}, 32'h1);

      // Test 1: one cell 00..34
      fill_cell(8'h00, 8'h01);
      send_cell();
      repeat (2) @(negedge clk);
      check("t1_clav", {31'd0, Rx_clav}, 32'h1);
      Rx_en = 1'b0;
      wait_drain();
      @(negedge clk);
      check("t1_clav_after", {31'd0, Rx_clav}, 32'h0);
      check("t1_count", rx_count, 53);

      // Test 2: pause after byte 9
      Rx_en = 1'b1;
      fill_cell(8'h00, 8'h01);
      send_cell();
      repeat (2) @(negedge clk);
      base  = rx_count;
      Rx_en = 1'b0;
      wait_rx(base + 10);
      Rx_en = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #2;
         check("t2_pause_data", {24'd0, Rx_data}, 32'h09);
         check("t2_pause_soc", {31'd0, Rx_soc}, 32'h0);
      end
      Rx_en = 1'b0;
      wait_drain();
      check("t2_count", rx_count, base + 53);

      // Test 3: fill both slots, third cell waits for a free slot
      @(negedge clk);
      Rx_en = 1'b1;
      base  = rx_count;
      fill_cell(8'h40, 8'h01);
      send_cell();
      fill_cell(8'h80, 8'h01);
      send_cell();
      @(negedge clk);
      check("t3_ready_full", {31'd0, cell_ready}, 32'h0);
      check("t3_clav", {31'd0, Rx_clav}, 32'h1);
      fork
         begin
            fill_cell(8'hC0, 8'h01);
            send_cell();
         end
         begin
            repeat (4) @(negedge clk);
            Rx_en = 1'b0;
         end
      join
      wait_drain();
      check("t3_count", rx_count, base + 159);

      // Test 4: partial cell dropped by a new sop
      @(negedge clk);
      Rx_en = 1'b1;
      base  = rx_count;
      put_byte(8'h11, 1'b1);
      repeat (19) put_byte(8'h22, 1'b0);
      fill_cell(8'hA5, 8'h00);
      send_cell();
      @(negedge clk);
      check("t4_drop", {24'd0, drop_cnt}, 32'h1);
      Rx_en = 1'b0;
      wait_drain();
      repeat (60) @(negedge clk);
      check("t4_count", rx_count, base + 53);
      check("t4_clav", {31'd0, Rx_clav}, 32'h0);

      // Test 5: reset in the middle of an output cell
      Rx_en = 1'b1;
      fill_cell(8'h10, 8'h01);
      send_cell();
      repeat (2) @(negedge clk);
      base  = rx_count;
      Rx_en = 1'b0;
      wait_rx(base + 31);
      rst_n = 1'b0;
      @(negedge clk);
      check("t5_data", {24'd0, Rx_data}, 32'h0);
      check("t5_soc", {31'd0, Rx_soc}, 32'h0);
      check("t5_clav", {31'd0, Rx_clav}, 32'h0);
      check("t5_ready", {31'd0, cell_ready}, 32'h0);
      check("t5_drop", {24'd0, drop_cnt}, 32'h0);
      exp_q.delete();
      rst_n = 1'b1;
      repeat (70) @(negedge clk);
      check("t5_clav_after", {31'd0, Rx_clav}, 32'h0);
      check("t5_state", {31'd0, dbg_state}, {31'd0, IDLE});
      check("t5_ready_after", {31'd0, cell_ready}, 32'h1);

      // Test 6: stray bytes before sop, then header byte 4 handling
      Rx_en = 1'b1;
      base  = rx_count;
      put_byte(8'h77, 1'b0);
      put_byte(8'h77, 1'b0);
      fill_cell(8'h30, 8'h01);
      tx_cell[0] = 8'h00; tx_cell[1] = 8'h00; tx_cell[2] = 8'h00; tx_cell[3] = 8'h01;
      tx_cell[4] = 8'hFF;
      for (int i = 0; i < 5; i++) exp_cell[i] = tx_cell[i];
`ifdef UTOPIA_HEC_GEN_EN
      exp_cell[4] = 8'h52;
`endif
      send_cell();
      fill_cell(8'h60, 8'h01);
      tx_cell[0] = 8'h00; tx_cell[1] = 8'h00; tx_cell[2] = 8'h00; tx_cell[3] = 8'h00;
      tx_cell[4] = 8'hFF;
      for (int i = 0; i < 5; i++) exp_cell[i] = tx_cell[i];
`ifdef UTOPIA_HEC_GEN_EN
      exp_cell[4] = 8'h55;
`endif
      send_cell();
      Rx_en = 1'b0;
      wait_drain();
      check("t6_count", rx_count, base + 106);
      check("t6_drop", {24'd0, drop_cnt}, 32'h0);

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
